// File: rtl/wordcell_access_ctrl.sv
// Request-driven sequencer for the word-cell array: setup, select pulse
// and recover phases around each read or write, then a held response.
module wordcell_access_ctrl #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 2,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [DATA_W-1:0]       req_wdata,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic                    rsp_err,
    output logic                    op,
    output logic [DEPTH-1:0]        sel,
    output logic [DATA_W-1:0]       in_bus,
    input  logic [DEPTH*DATA_W-1:0] rd_bus
);

    typedef enum logic [2:0] {IDLE, SETUP, PULSE, RECOVER, RESP} state_t;

    localparam int CMAX  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int CNT_W = $clog2(CMAX + 1);
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               req_ready_d, rsp_valid_d, rsp_err_d, op_d;
    logic [DATA_W-1:0]  rsp_rdata_d, in_bus_d, word;
    logic [DEPTH-1:0]   sel_d, one_hot;
    logic               addr_ok;

    // Address decode and read-word mux, both driven from the latched address
    always_comb begin
        addr_ok = ({1'b0, addr_q} < DEPTH_V);
        one_hot = '0;
        word    = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (addr_q == ADDR_W'(k)) begin
                one_hot[k] = 1'b1;
                word       = rd_bus[k*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        addr_d      = addr_q;
        req_ready_d = req_ready;
        rsp_valid_d = rsp_valid;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        op_d        = op;
        sel_d       = sel;
        in_bus_d    = in_bus;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    addr_d      = req_addr;
                    op_d        = req_we;
                    in_bus_d    = req_we ? req_wdata : '0;
                    req_ready_d = 1'b0;
                    cnt_d       = CNT_W'(SETUP_CYC - 1);
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    cnt_d   = CNT_W'(PULSE_CYC - 1);
                    state_d = PULSE;
                    if (addr_ok) sel_d = one_hot;
                    else rsp_err_d = 1'b1;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    sel_d   = '0;
                    state_d = RECOVER;
                    if (!op && addr_ok) rsp_rdata_d = word;
                end else begin
                    cnt_d = cnt - 1'b1;
                end
            end
            RECOVER: begin
                op_d        = 1'b0;
                in_bus_d    = '0;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            addr_q    <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            op        <= 1'b0;
            sel       <= '0;
            in_bus    <= '0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            addr_q    <= addr_d;
            req_ready <= req_ready_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
            op        <= op_d;
            sel       <= sel_d;
            in_bus    <= in_bus_d;
        end
    end

endmodule

// File: doc/wordcell_access_ctrl.md
Name: wordcell_access_ctrl

Overview:
- Request-driven access sequencer sitting directly upstream and downstream of the word-cell array (DEPTH word cells of DATA_W latch bitcells each).
- Accepts one read/write request at a time over a valid/ready handshake.
- Drives the shared op/in_bus lines and the one-hot per-word sel lines through a setup, pulse and recover sequence.
- Captures the selected word's out_bus for reads and returns a response over a second valid/ready handshake.

Parameters:
- DATA_W, 8, width of one word cell.
- DEPTH, 4, number of word cells; 2..16.
- ADDR_W, 2, request address width; 2**ADDR_W >= DEPTH.
- SETUP_CYC, 1, cycles op/in_bus are stable before sel asserts; >= 1.
- PULSE_CYC, 2, cycles sel is held asserted; >= 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  target word index.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  address >= DEPTH.
- op  out  1  to all word cells: 1 = write, 0 = read.
- sel  out  DEPTH  one-hot word select; bit k drives sel_x of word k.
- in_bus  out  DATA_W  shared write data to all word cells.
- rd_bus  in  DEPTH*DATA_W  concatenated out_bus of all words; word k = bits [k*DATA_W +: DATA_W].

Behaviour:
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, op=0, sel=0, in_bus=0. State is IDLE and counters are 0.
- Reset is synchronous. If asserted mid-operation, every output takes its reset value at that edge, and any request or response in flight is dropped.
- FSM states: IDLE, SETUP, PULSE, RECOVER, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready, latch we, addr and wdata; deassert req_ready; go to SETUP.
  - Set op=we and in_bus = we ? wdata : 0; sel stays 0.
- SETUP:
  - Hold for SETUP_CYC cycles (down-counter).
  - Then go to PULSE, setting sel = one-hot(addr).
  - If addr >= DEPTH, sel stays 0 and the error flag is set.
- PULSE:
  - Hold sel, op and in_bus for PULSE_CYC cycles.
  - On the edge ending the last PULSE cycle: sel<=0 and go to RECOVER.
  - On that same edge, for reads with a valid address, capture rsp_rdata <= rd_bus word[addr].
- RECOVER: one cycle with sel=0 and op/in_bus still held. At its end, op<=0, in_bus<=0, rsp_valid<=1; go to RESP.
- RESP:
  - rsp_valid stays 1 and rsp_rdata/rsp_err stay stable until rsp_valid && rsp_ready.
  - At that edge: rsp_valid<=0, rsp_rdata<=0, rsp_err<=0, req_ready<=1; go to IDLE.
- Latency: with the accept edge at cycle 0, sel is high in cycles SETUP_CYC+1 .. SETUP_CYC+PULSE_CYC. rsp_valid first rises in cycle SETUP_CYC+PULSE_CYC+2 (cycle 5 at defaults).
- Back-to-back operation: the next request is accepted no earlier than the cycle after the response handshake. Throughput is one request per SETUP_CYC+PULSE_CYC+3 cycles when rsp_ready is held at 1.
- Invariants:
  - sel is 0 or one-hot at all times.
  - op and in_bus never change while any sel bit is 1.
  - sel is never 1 in IDLE, SETUP or RESP.
- Request inputs are ignored when req_ready=0.
- rsp_ready is ignored when rsp_valid=0.
- An error response has rsp_err=1 and rsp_rdata=0, and no word cell is selected.

Test Plan:
- Reset then idle -> req_ready=1, sel=0, op=0, in_bus=0, rsp_valid=0; hold rst mid-PULSE -> sel=0 and req_ready=1 on the next edge.
- Write addr=2, data=0xA5 (defaults) -> op=1 and in_bus=0xA5 from cycle 1; sel=4'b0100 in cycles 2-3; rsp_valid in cycle 5 with rsp_rdata=0, rsp_err=0; word 2 stored_data=0xA5.
- Read addr=2 after the write, rsp_ready=1 -> op=0, sel=4'b0100 in cycles 2-3, rsp_rdata=0xA5 in cycle 5, req_ready=1 in cycle 6.
- Write all words (0x11, 0x22, 0x33, 0x44) then read 3,0,1,2 -> 0x44, 0x11, 0x22, 0x33; sel checked one-hot every cycle.
- Response backpressure: read with rsp_ready=0 for 4 cycles -> rsp_valid and rsp_rdata stable and req_ready=0 throughout; a req_valid pulse during that window is not accepted.
- DEPTH=3, ADDR_W=2, read addr=3 -> sel stays 0 for the whole access, rsp_err=1, rsp_rdata=0; SETUP_CYC=2, PULSE_CYC=3 -> rsp_valid in cycle 7.
